// File: rtl/jtcop_pcm_pkg.sv
// Shared types for the ADPCM sample-ROM responder: fetch FSM states and cache entry layout.
// Holds no logic, so it adds no latency and applies no backpressure.
package jtcop_pcm_pkg;

    localparam int PCM_AW   = 18;
    localparam int NENTRIES = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } pcm_state_e;

    typedef struct packed {
        logic              valid;
        logic [PCM_AW-2:0] tag;
        logic [15:0]       word;
    } pcm_entry_t;

endpackage

// File: rtl/jtcop_pcm_tagcmp.sv
// Two-entry word-cache tag compare: returns hit, index of the matching entry and its word.
// Purely combinational (zero latency); no flow control.
module jtcop_pcm_tagcmp
    import jtcop_pcm_pkg::*;
(
    input  pcm_entry_t [NENTRIES-1:0] i_ent,
    input  logic [PCM_AW-2:0]         i_tag,
    output logic                      o_hit,
    output logic                      o_idx,
    output logic [15:0]               o_word
);

    always_comb begin
        o_hit  = 1'b0;
        o_idx  = 1'b0;
        o_word = 16'h0000;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (i_ent[i].valid && i_ent[i].tag == i_tag) begin
                o_hit  = 1'b1;
                o_idx  = 1'(i);
                o_word = i_ent[i].word;
            end
        end
    end

endmodule

// File: rtl/jtcop_pcm_romrq.sv
// ADPCM byte port to 16-bit SDRAM word fetcher with a 2-entry word cache.
// Hits answer one cycle after the address; misses hold sdram_req until ack, data visible 2 cycles after rdy.
module jtcop_pcm_romrq
    import jtcop_pcm_pkg::*;
#(
    parameter int              AW           = 18,
    parameter logic [AW-2:0]   SDRAM_OFFSET = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pcm_cs,
    input  logic [AW-1:0] pcm_addr,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic          sdram_req,
    output logic [AW-2:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_din
);

    pcm_entry_t [NENTRIES-1:0] r_cache;
    pcm_state_e                r_state;
    logic                      r_ptr;
    logic [AW-2:0]             r_ftag;

    logic [AW-2:0] w_tag;
    logic          w_hit;
    logic          w_hit_idx;
    logic [15:0]   w_hit_word;
    logic          w_dup;
    logic          w_dup_idx;
    logic [15:0]   w_dup_word;
    logic          w_fill;
    logic          w_unused;

    assign w_tag = pcm_addr[AW-1:1];

    jtcop_pcm_tagcmp u_hit (
        .i_ent  (r_cache),
        .i_tag  (w_tag),
        .o_hit  (w_hit),
        .o_idx  (w_hit_idx),
        .o_word (w_hit_word)
    );

    // Same comparator against the in-flight tag keeps a fill from duplicating an entry.
    jtcop_pcm_tagcmp u_dup (
        .i_ent  (r_cache),
        .i_tag  (r_ftag),
        .o_hit  (w_dup),
        .o_idx  (w_dup_idx),
        .o_word (w_dup_word)
    );

    assign w_unused = ^{w_hit_idx, w_dup_word};

    assign w_fill = sdram_rdy &&
                    ((r_state == ST_WAIT_ACK && sdram_ack) || r_state == ST_WAIT_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_ok   <= 1'b0;
            pcm_data <= 8'h00;
        end else if (pcm_cs && w_hit) begin
            pcm_ok   <= 1'b1;
            pcm_data <= pcm_addr[0] ? w_hit_word[15:8] : w_hit_word[7:0];
        end else begin
            pcm_ok   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cache    <= '0;
            r_ptr      <= 1'b0;
            r_ftag     <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pcm_cs && !w_hit) begin
                        r_ftag     <= w_tag;
                        sdram_addr <= w_tag + SDRAM_OFFSET;
                        sdram_req  <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_state   <= sdram_rdy ? ST_IDLE : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (sdram_rdy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_fill) begin
                if (w_dup) begin
                    r_cache[w_dup_idx] <= '{valid: 1'b1, tag: r_ftag, word: sdram_din};
                end else begin
                    r_cache[r_ptr] <= '{valid: 1'b1, tag: r_ftag, word: sdram_din};
                    r_ptr          <= ~r_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtcop_pcm_romrq.sv
// Bench for jtcop_pcm_romrq: directed sequences, a vector table and randomized traffic,
// all checked every cycle against a transaction-level cache model.
module tb_jtcop_pcm_romrq;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcm_cs;
    logic [17:0] pcm_addr;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        sdram_req;
    logic [16:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_din;

    always #5 clk = ~clk;

    jtcop_pcm_romrq #(.AW(18), .SDRAM_OFFSET(17'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcm_cs     (pcm_cs),
        .pcm_addr   (pcm_addr),
        .pcm_data   (pcm_data),
        .pcm_ok     (pcm_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: cached words in fill order (oldest first), plus one outstanding fetch.
    logic [16:0] q_tag[$];
    logic [15:0] q_word[$];
    bit          m_pend  = 1'b0;
    bit          m_acked = 1'b0;
    logic [16:0] m_ftag  = '0;
    logic        e_ok    = 1'b0;
    logic [7:0]  e_data  = 8'h00;
    logic        e_req   = 1'b0;
    logic [16:0] e_saddr = '0;
    int          req_rises = 0;
    logic        prev_req  = 1'b0;

    typedef struct {
        logic        cs;
        logic [17:0] addr;
        logic        ok;
        logic [7:0]  data;
        logic        req;
    } vec_t;
    vec_t tbl[10];

    logic [16:0] pool[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int find(input logic [16:0] t);
        foreach (q_tag[i]) if (q_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic void fill(input logic [16:0] t, input logic [15:0] w);
        int idx;
        idx = find(t);
        if (idx >= 0) begin
            q_word[idx] = w;
        end else begin
            q_tag.push_back(t);
            q_word.push_back(w);
            if (q_tag.size() > 2) begin
                void'(q_tag.pop_front());
                void'(q_word.pop_front());
            end
        end
    endfunction

    // Predict the effect of the coming edge, clock it, then compare every output.
    task automatic step();
        logic [16:0] t;
        int          hi;
        t  = pcm_addr[17:1];
        hi = find(t);
        if (rst) begin
            q_tag.delete();
            q_word.delete();
            m_pend  = 1'b0;
            m_acked = 1'b0;
            e_ok    = 1'b0;
            e_data  = 8'h00;
            e_req   = 1'b0;
            e_saddr = '0;
        end else begin
            e_ok = pcm_cs && (hi >= 0);
            if (e_ok) e_data = pcm_addr[0] ? q_word[hi][15:8] : q_word[hi][7:0];
            if (m_pend) begin
                if ((m_acked || sdram_ack) && sdram_rdy) begin
                    fill(m_ftag, sdram_din);
                    m_pend = 1'b0;
                    e_req  = 1'b0;
                end else if (sdram_ack) begin
                    m_acked = 1'b1;
                    e_req   = 1'b0;
                end
            end else if (pcm_cs && hi < 0) begin
                m_pend  = 1'b1;
                m_acked = 1'b0;
                m_ftag  = t;
                e_req   = 1'b1;
                e_saddr = t;
            end
        end
        @(posedge clk);
        #1;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        chk("pcm_ok",     32'(pcm_ok),     32'(e_ok));
        chk("pcm_data",   32'(pcm_data),   32'(e_data));
        chk("sdram_req",  32'(sdram_req),  32'(e_req));
        chk("sdram_addr", 32'(sdram_addr), 32'(e_saddr));
        if (sdram_req && !prev_req) req_rises++;
        prev_req = sdram_req;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 20) begin
            step();
            n++;
        end
        chk("wait_req", 32'(sdram_req), 32'd1);
    endtask

    // ack after ad idle cycles; rdy rd cycles after ack (rd=0: same cycle as ack).
    task automatic serve(input int ad, input int rd, input logic [15:0] w);
        wait_req();
        repeat (ad) step();
        sdram_ack = 1'b1;
        if (rd == 0) begin
            sdram_rdy = 1'b1;
            sdram_din = w;
        end
        step();
        if (rd > 0) begin
            repeat (rd - 1) step();
            sdram_rdy = 1'b1;
            sdram_din = w;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pcm_cs = 1'b1; pcm_addr = 18'h0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = 16'h0;

        // Reset, then first request right after release
        repeat (3) begin
            step();
            chk("rst_ok",  32'(pcm_ok),    32'd0);
            chk("rst_req", 32'(sdram_req), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("first_req", 32'(sdram_req), 32'd1);
        serve(0, 1, 16'h1234);

        // Cold miss then hit on the other byte
        pcm_addr = 18'h00100;
        step();
        chk("cold_req",   32'(sdram_req),  32'd1);
        chk("cold_saddr", 32'(sdram_addr), 32'h00080);
        serve(4, 3, 16'hA55A);
        chk("cold_ok_early", 32'(pcm_ok), 32'd0);
        step();
        chk("cold_ok",   32'(pcm_ok),   32'd1);
        chk("cold_data", 32'(pcm_data), 32'h5A);
        pcm_addr = 18'h00101;
        step();
        chk("hit_ok",   32'(pcm_ok),    32'd1);
        chk("hit_data", 32'(pcm_data),  32'hA5);
        chk("hit_req",  32'(sdram_req), 32'd0);

        // Eviction order
        rst = 1'b1; pcm_cs = 1'b0; step(); rst = 1'b0; pcm_cs = 1'b1;
        pcm_addr = 18'h00100; serve(1, 1, 16'h8080);
        pcm_addr = 18'h00102; serve(1, 1, 16'h8181);
        pcm_addr = 18'h00104; serve(0, 2, 16'h8282);
        step();
        chk("ev82_data", 32'(pcm_data), 32'h82);
        pcm_addr = 18'h00102; step();
        chk("ev81_hit", 32'(pcm_ok), 32'd1);
        pcm_addr = 18'h00100; step();
        chk("ev80_refetch", 32'(sdram_req), 32'd1);
        serve(0, 1, 16'h8088);
        step();
        chk("ev80_data", 32'(pcm_data), 32'h88);
        pcm_addr = 18'h00104; step();
        chk("ev82_hit", 32'(pcm_ok),    32'd1);
        chk("ev82_req", 32'(sdram_req), 32'd0);
        pcm_addr = 18'h00102; step();
        chk("ev81_gone", 32'(sdram_req), 32'd1);
        serve(0, 1, 16'h8181);

        // Address change while waiting for data
        req_rises = 0;
        pcm_addr = 18'h00200;
        wait_req();
        sdram_ack = 1'b1; step();
        pcm_addr = 18'h00400;
        step(); step();
        chk("chg_ok_low", 32'(pcm_ok), 32'd0);
        sdram_rdy = 1'b1; sdram_din = 16'h2222; step();
        serve(1, 2, 16'h4444);
        step();
        chk("chg_new_ok",   32'(pcm_ok),    32'd1);
        chk("chg_new_data", 32'(pcm_data),  32'h44);
        chk("chg_episodes", 32'(req_rises), 32'd2);
        pcm_addr = 18'h00200; step();
        chk("chg_old_data", 32'(pcm_data),  32'h22);
        chk("chg_old_req",  32'(sdram_req), 32'd0);

        // Coincident ack/rdy, then cs drop on a missing address
        pcm_addr = 18'h00600;
        serve(1, 0, 16'h6666);
        step();
        chk("coinc_ok",   32'(pcm_ok),   32'd1);
        chk("coinc_data", 32'(pcm_data), 32'h66);
        pcm_cs = 1'b0; pcm_addr = 18'h00800;
        repeat (4) begin
            step();
            chk("csoff_req", 32'(sdram_req), 32'd0);
            chk("csoff_ok",  32'(pcm_ok),    32'd0);
        end

        // Vector table over a known two-word cache
        rst = 1'b1; step(); rst = 1'b0; pcm_cs = 1'b1;
        pcm_addr = 18'h00020; serve(0, 1, 16'hBEEF);
        pcm_addr = 18'h00022; serve(0, 1, 16'hC0DE);
        tbl[0] = '{1'b1, 18'h00020, 1'b1, 8'hEF, 1'b0};
        tbl[1] = '{1'b1, 18'h00021, 1'b1, 8'hBE, 1'b0};
        tbl[2] = '{1'b0, 18'h00021, 1'b0, 8'hBE, 1'b0};
        tbl[3] = '{1'b1, 18'h00023, 1'b1, 8'hC0, 1'b0};
        tbl[4] = '{1'b1, 18'h00022, 1'b1, 8'hDE, 1'b0};
        tbl[5] = '{1'b0, 18'h00040, 1'b0, 8'hDE, 1'b0};
        tbl[6] = '{1'b1, 18'h00041, 1'b0, 8'hDE, 1'b1};
        tbl[7] = '{1'b1, 18'h00020, 1'b1, 8'hEF, 1'b1};
        tbl[8] = '{1'b0, 18'h00023, 1'b0, 8'hEF, 1'b1};
        tbl[9] = '{1'b1, 18'h00023, 1'b1, 8'hC0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            pcm_cs   = tbl[i].cs;
            pcm_addr = tbl[i].addr;
            step();
            chk("tbl_ok",   32'(pcm_ok),    32'(tbl[i].ok));
            chk("tbl_data", 32'(pcm_data),  32'(tbl[i].data));
            chk("tbl_req",  32'(sdram_req), 32'(tbl[i].req));
        end

        // Randomized traffic against the model
        pool[0] = 17'h00000; pool[1] = 17'h00001; pool[2] = 17'h00002;
        pool[3] = 17'h00003; pool[4] = 17'h1FFFF; pool[5] = 17'h00010;
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 399) == 0);
            pcm_cs = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                pcm_addr = {pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1))};
            if (m_pend && !m_acked) begin
                sdram_ack = ($urandom_range(0, 2) == 0);
                sdram_rdy = sdram_ack ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 7) == 0);
            end else if (m_pend) begin
                sdram_rdy = ($urandom_range(0, 2) == 0);
            end else begin
                sdram_rdy = ($urandom_range(0, 19) == 0);
            end
            sdram_din = 16'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
